energy_regulator_nch: RTL and testbench
=======================================

Name: energy_regulator_nch

Overview:
- Parametrised next generation of the energy regulator: merges inc/dec requests from CHANNELS state controllers into a saturating energy level.
- The level relaxes toward SETPOINT on its own when no requests arrive.
- It is a registered block and emits single-cycle energy_inc/energy_dec pulses, one per level change, to the downstream mood logic.
- Sits between the per-stimulus state controllers and the mood/energy classifier.

Parameters:
- CHANNELS, 2, number of request channels (1..8).
- WIDTH, 4, energy level width; range 0..2^WIDTH-1.
- RESET_LEVEL, 8, level loaded on reset.
- SETPOINT, 8, resting level targeted by decay.
- DECAY_PERIOD, 16, consecutive quiet cycles per decay step; 0 disables decay.
- LOW_TH, 3, hysteresis low threshold (optional feature only).
- HIGH_TH, 6, hysteresis high threshold (optional feature only).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- freeze, input, 1, holds all state while high.
- state_controller_inc, input, CHANNELS, per-channel increment request, sampled each cycle.
- state_controller_dec, input, CHANNELS, per-channel decrement request, sampled each cycle.
- energy_level, output, WIDTH, current registered level.
- energy_inc, output, 1, one-cycle pulse: level rose on the last edge.
- energy_dec, output, 1, one-cycle pulse: level fell on the last edge.
- at_max, output, 1, energy_level == 2^WIDTH-1 (combinational from register).
- at_min, output, 1, energy_level == 0 (combinational from register).
- exhausted, output, 1, hysteresis flag (optional feature), registered.

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - energy_level = RESET_LEVEL.
  - Decay counter = 0.
  - energy_inc = energy_dec = 0.
  - exhausted = 1 if RESET_LEVEL <= LOW_TH, else 0.
  - Reset asserted mid-operation clears all state immediately; pending requests are discarded.
- Per-channel resolution: inc and dec both high on the same channel cancel; that channel contributes 0.
- Net request: net = popcount(effective inc) - popcount(effective dec), signed, width clog2(CHANNELS+1)+1.
- Update when freeze=0 and net != 0:
  - level_next = clamp(level + net, 0, 2^WIDTH-1), computed at width WIDTH+2 before clamping; no wrap-around.
  - Decay counter is cleared to 0.
- Update when freeze=0 and net == 0 (idle or fully balanced):
  - If DECAY_PERIOD == 0 or level == SETPOINT: counter is cleared to 0; level holds.
  - Else if counter == DECAY_PERIOD-1: level steps by exactly 1 toward SETPOINT; counter clears to 0.
  - Else: counter increments.
  - Counter width is clog2(DECAY_PERIOD+1).
- Pulses:
  - energy_inc = 1 on the cycle after an edge where level_next > level.
  - energy_dec = 1 on the cycle after an edge where level_next < level.
  - Otherwise both are 0, including request-against-saturation with no change. Never both high.
  - Latency: a request sampled at edge N appears on energy_level and the pulses after edge N; one cycle.
- freeze=1: level and counter hold, pulses are 0, requests are ignored (not queued).
- Decay steps produce energy_inc/energy_dec pulses exactly like request-driven changes.

Optional Feature:
- Macro: ENERGY_REGULATOR_HYST_EN.
- Defined: exhausted is a registered flag with hysteresis.
  - Sets to 1 on the edge where level_next <= LOW_TH.
  - Clears to 0 on the edge where level_next >= HIGH_TH.
  - Otherwise holds.
  - Updates only when freeze=0.
- Undefined: exhausted is tied to 0; LOW_TH/HIGH_TH are unused; no hysteresis logic is synthesised.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> energy_level=8, energy_inc=energy_dec=0 immediately; exhausted=0.
- Multi-channel: inc=2'b11, dec=2'b00 for one cycle from 8 -> energy_level=10 after one edge, energy_inc high exactly one cycle; then inc=2'b01, dec=2'b10 -> level stays 10, no pulse.
- Cancel plus saturation:
  - inc=2'b01 with dec=2'b01 -> no change, decay counter advances.
  - From 14, inc=2'b11 -> 15, at_max=1, one energy_inc pulse.
  - Holding inc=2'b11 -> stays 15, no further pulses.
- Decay:
  - Level 12, all requests idle -> 11 after 16 quiet cycles, 10 after 32.
  - Continues to 8 then holds; one energy_dec pulse per step.
  - A request at quiet cycle 10 restarts the count.
- Freeze: freeze=1 at quiet cycle 8 of decay, hold 20 cycles with requests toggling -> level and counter unchanged, no pulses; after release, the decay step occurs 8 cycles later.
- Hysteresis (macro defined):
  - Dec from 8 down to 3 -> exhausted sets at 3.
  - Rising to 5 -> exhausted stays 1.
  - Reaching 6 -> exhausted clears.
  - Macro undefined -> exhausted constant 0.

Source files
------------

// File: rtl/energy_regulator_nch.sv
// Saturating energy level fed by CHANNELS inc/dec request lines, relaxing toward SETPOINT when quiet.
// Optional hysteresis "exhausted" flag enabled by defining ENERGY_REGULATOR_HYST_EN.
module energy_regulator_nch #(
   parameter int CHANNELS     = 2,
   parameter int WIDTH        = 4,
   parameter int RESET_LEVEL  = 8,
   parameter int SETPOINT     = 8,
   parameter int DECAY_PERIOD = 16,
   parameter int LOW_TH       = 3,
   parameter int HIGH_TH      = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic [CHANNELS-1:0] state_controller_inc,
   input  logic [CHANNELS-1:0] state_controller_dec,
   output logic [WIDTH-1:0]    energy_level,
   output logic                energy_inc,
   output logic                energy_dec,
   output logic                at_max,
   output logic                at_min,
   output logic                exhausted
);

   localparam int NW = $clog2(CHANNELS + 1) + 1;
   localparam int SW = (WIDTH + 2 > NW + 1) ? WIDTH + 2 : NW + 1;
   localparam int CW = (DECAY_PERIOD == 0) ? 1 : $clog2(DECAY_PERIOD + 1);
   localparam logic [WIDTH-1:0]     MAX_LEVEL  = '1;
   localparam logic [WIDTH-1:0]     SET_LEVEL  = WIDTH'(SETPOINT);
   localparam logic [CW-1:0]        LAST_COUNT = (DECAY_PERIOD == 0) ? '0 : CW'(DECAY_PERIOD - 1);
   localparam logic signed [SW-1:0] MAX_SUM    = SW'(2 ** WIDTH - 1);

   logic [WIDTH-1:0]      level_q, level_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  inc_q, inc_d;
   logic                  dec_q, dec_d;
   logic [CHANNELS-1:0]   effInc, effDec;
   logic [NW-1:0]         incCount, decCount;
   logic signed [NW-1:0]  netReq;
   logic signed [SW-1:0]  sumWide;

   // A channel raising inc and dec together cancels itself out.
   assign effInc = state_controller_inc & ~state_controller_dec;
   assign effDec = state_controller_dec & ~state_controller_inc;

   always_comb begin
      incCount = '0;
      decCount = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         incCount = incCount + NW'(effInc[i]);
         decCount = decCount + NW'(effDec[i]);
      end
      netReq = $signed(incCount - decCount);
   end

   always_comb begin
      level_d = level_q;
      count_d = count_q;
      sumWide = $signed({{(SW-WIDTH){1'b0}}, level_q}) + $signed({{(SW-NW){netReq[NW-1]}}, netReq});
      if (!freeze) begin
         if (netReq != '0) begin
            if (sumWide < 0)
               level_d = '0;
            else if (sumWide > MAX_SUM)
               level_d = MAX_LEVEL;
            else
               level_d = sumWide[WIDTH-1:0];
            count_d = '0;
         end else if (DECAY_PERIOD == 0 || level_q == SET_LEVEL) begin
            count_d = '0;
         end else if (count_q == LAST_COUNT) begin
            count_d = '0;
            level_d = (level_q > SET_LEVEL) ? level_q - WIDTH'(1) : level_q + WIDTH'(1);
         end else begin
            count_d = count_q + CW'(1);
         end
      end
      inc_d = (level_d > level_q);
      dec_d = (level_d < level_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= WIDTH'(RESET_LEVEL);
         count_q <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         count_q <= count_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
      end
   end

   assign energy_level = level_q;
   assign energy_inc   = inc_q;
   assign energy_dec   = dec_q;
   assign at_max       = (level_q == MAX_LEVEL);
   assign at_min       = (level_q == '0);

`ifdef ENERGY_REGULATOR_HYST_EN
   logic exh_q, exh_d;

   // Thresholds look at the level being loaded, so the flag lines up with energy_level.
   always_comb begin
      exh_d = exh_q;
      if (!freeze) begin
         if (int'(level_d) <= LOW_TH)
            exh_d = 1'b1;
         else if (int'(level_d) >= HIGH_TH)
            exh_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         exh_q <= (RESET_LEVEL <= LOW_TH);
      else
         exh_q <= exh_d;
   end

   assign exhausted = exh_q;
`else
   logic unused_th;
   assign unused_th = ^{LOW_TH, HIGH_TH};
   assign exhausted = 1'b0;
`endif

endmodule

// File: tb/tb_energy_regulator_nch.sv
// Scoreboard bench for energy_regulator_nch: directed scenarios followed by random requests.
// Exhausted expectations follow ENERGY_REGULATOR_HYST_EN.
module tb_energy_regulator_nch;

   localparam int CH   = 2;
   localparam int W    = 4;
   localparam int RL   = 8;
   localparam int SP   = 8;
   localparam int DP   = 16;
   localparam int LT   = 3;
   localparam int HT   = 6;
   localparam int MAXL = 2 ** W - 1;

   typedef struct packed {
      logic [W-1:0] level;
      logic         inc;
      logic         dec;
      logic         mx;
      logic         mn;
      logic         exh;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          freeze;
   logic [CH-1:0] scInc, scDec;
   logic [W-1:0]  energyLevel;
   logic          energyInc, energyDec, atMax, atMin, exhausted;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   mLevel;
   int   mCnt;
   bit   mExh;

   always #5 clk = ~clk;

   energy_regulator_nch #(
      .CHANNELS(CH), .WIDTH(W), .RESET_LEVEL(RL), .SETPOINT(SP),
      .DECAY_PERIOD(DP), .LOW_TH(LT), .HIGH_TH(HT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .freeze(freeze),
      .state_controller_inc(scInc),
      .state_controller_dec(scDec),
      .energy_level(energyLevel),
      .energy_inc(energyInc),
      .energy_dec(energyDec),
      .at_max(atMax),
      .at_min(atMin),
      .exhausted(exhausted)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic bit resetExh();
`ifdef ENERGY_REGULATOR_HYST_EN
      return (RL <= LT);
`else
      return 1'b0;
`endif
   endfunction

   // Drives one cycle of requests, predicts the level after the next edge from the
   // behavioural rules, and hands that prediction to the monitor once the edge has happened.
   task automatic applyStimulus(input logic [CH-1:0] inc, input logic [CH-1:0] dec, input logic frz);
      int   ni = 0;
      int   nd = 0;
      int   nl;
      exp_t e;
      scInc  = inc;
      scDec  = dec;
      freeze = frz;
      for (int c = 0; c < CH; c++) begin
         if (inc[c] && !dec[c]) ni++;
         if (dec[c] && !inc[c]) nd++;
      end
      nl = mLevel;
      if (!frz) begin
         if (ni != nd) begin
            nl = mLevel + ni - nd;
            if (nl < 0) nl = 0;
            if (nl > MAXL) nl = MAXL;
            mCnt = 0;
         end else if (DP == 0 || mLevel == SP) begin
            mCnt = 0;
         end else if (mCnt == DP - 1) begin
            nl   = (mLevel > SP) ? mLevel - 1 : mLevel + 1;
            mCnt = 0;
         end else begin
            mCnt++;
         end
`ifdef ENERGY_REGULATOR_HYST_EN
         if (nl <= LT) mExh = 1'b1;
         else if (nl >= HT) mExh = 1'b0;
`endif
      end
      e.level = W'(nl);
      e.inc   = (nl > mLevel);
      e.dec   = (nl < mLevel);
      e.mx    = (nl == MAXL);
      e.mn    = (nl == 0);
      e.exh   = mExh;
      mLevel  = nl;
      @(posedge clk);
      expQ.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus('0, '0, 1'b0);
   endtask

   // Asserts reset between edges and checks the outputs clear without waiting for a clock.
   task automatic doReset();
      @(negedge clk);
      scInc  = '0;
      scDec  = '0;
      freeze = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("reset_level", int'(energyLevel), RL);
      checkOutput("reset_inc", int'(energyInc), 0);
      checkOutput("reset_dec", int'(energyDec), 0);
      checkOutput("reset_exhausted", int'(exhausted), int'(resetExh()));
      mLevel = RL;
      mCnt   = 0;
      mExh   = resetExh();
      #1 rst = 1'b0;
      applyStimulus('0, '0, 1'b0);
   endtask

   initial begin : monitor
      exp_t m;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            m = expQ.pop_front();
            checkOutput("level", int'(energyLevel), int'(m.level));
            checkOutput("inc_pulse", int'(energyInc), int'(m.inc));
            checkOutput("dec_pulse", int'(energyDec), int'(m.dec));
            checkOutput("at_max", int'(atMax), int'(m.mx));
            checkOutput("at_min", int'(atMin), int'(m.mn));
            checkOutput("exhausted", int'(exhausted), int'(m.exh));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : stimulus
      rst    = 1'b1;
      freeze = 1'b0;
      scInc  = '0;
      scDec  = '0;
      mLevel = RL;
      mCnt   = 0;
      mExh   = resetExh();
      #2;
      checkOutput("init_level", int'(energyLevel), RL);
      checkOutput("init_pulses", int'({energyInc, energyDec}), 0);
      #2 rst = 1'b0;
      applyStimulus('0, '0, 1'b0);

      // Multi-channel merge, balanced channels, same-channel cancel.
      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b01, 2'b10, 1'b0);
      applyStimulus(2'b01, 2'b01, 1'b0);

      // Climb into saturation and hold there.
      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b11, 2'b00, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(2'b11, 2'b00, 1'b0);

      // Back to 12, then decay all the way to the setpoint and rest there.
      applyStimulus(2'b00, 2'b11, 1'b0);
      applyStimulus(2'b00, 2'b01, 1'b0);
      idle(72);

      // A request part-way through a quiet run restarts the count.
      applyStimulus(2'b11, 2'b00, 1'b0);
      idle(10);
      applyStimulus(2'b01, 2'b00, 1'b0);
      idle(20);

      // Freeze mid-count with requests toggling underneath.
      applyStimulus(2'b01, 2'b00, 1'b0);
      idle(8);
      for (int k = 0; k < 20; k++) applyStimulus(CH'($urandom), CH'($urandom), 1'b1);
      idle(10);

      // Walk down through the low threshold and back up past the high one.
      while (mLevel > LT) applyStimulus(2'b00, 2'b01, 1'b0);
      applyStimulus(2'b01, 2'b00, 1'b0);
      applyStimulus(2'b01, 2'b00, 1'b0);
      applyStimulus(2'b01, 2'b00, 1'b0);

      // Floor saturation.
      for (int k = 0; k < 5; k++) applyStimulus(2'b00, 2'b11, 1'b0);

      // Reset mid-operation while an inc pulse is showing.
      applyStimulus(2'b11, 2'b00, 1'b0);
      doReset();

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(15) == 0)
            idle($urandom_range(24, 4));
         else if ($urandom_range(2) == 0)
            applyStimulus('0, '0, ($urandom_range(7) == 0));
         else
            applyStimulus(CH'($urandom), CH'($urandom), ($urandom_range(7) == 0));
      end
      doReset();
      idle(3);

      repeat (2) @(negedge clk);
      #1;
      checkOutput("queue_drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
